ball_ctrl: RTL and testbench

Ball motion controller for Breakout. Owns the ball centre position and direction and drives `s_x`/`s_y` to every `block` instance. Consumes the OR-combined `hit_block` code from those instances and returns the `col_detected` acknowledge that clears them. Also handles wall and paddle bounces, serve, ball loss and lives.

---
 rtl/breakout_pkg.sv | 11 +
 rtl/ball_bounce.sv | 35 +++
 rtl/ball_ctrl.sv | 98 +++++++++
 tb/tb_ball_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// breakout_pkg: shared FSM states, block hit codes and default display geometry
package breakout_pkg;
  typedef enum logic [1:0] {SERVE, PLAY, LOST, OVER} state_t;
  localparam logic [1:0] HIT_NONE   = 2'b00;
  localparam logic [1:0] HIT_VERT   = 2'b01;
  localparam logic [1:0] HIT_HORZ   = 2'b10;
  localparam logic [1:0] HIT_CORNER = 2'b11;
  localparam int S_SIZE_DEF   = 5;
  localparam int D_WIDTH_DEF  = 640;
  localparam int D_HEIGHT_DEF = 480;
endpackage

// File: rtl/ball_bounce.sv
// ball_bounce: resolves next ball direction and loss from the freshly moved position
module ball_bounce import breakout_pkg::*; #(
  parameter int S_SIZE   = S_SIZE_DEF,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int D_HEIGHT = D_HEIGHT_DEF
) (
  input  logic        mv,
  input  logic [11:0] nx,
  input  logic [11:0] ny,
  input  logic [11:0] px1,
  input  logic [11:0] px2,
  input  logic [11:0] py1,
  input  logic        dx,
  input  logic        dy,
  input  logic [1:0]  hit,
  output logic        dx_n,
  output logic        dy_n,
  output logic        lost
);
  localparam logic [11:0] S  = 12'(S_SIZE);
  localparam logic [11:0] XR = 12'(D_WIDTH - 1 - S_SIZE);
  localparam logic [11:0] YB = 12'(D_HEIGHT - 1 - S_SIZE);
  logic tx, ty, wl, wr, wt, pad;
  always_comb begin
    tx   = hit == HIT_HORZ || hit == HIT_CORNER;
    ty   = hit == HIT_VERT || hit == HIT_CORNER;
    wl   = mv && nx <= S;
    wr   = mv && nx >= XR;
    wt   = mv && ny <= S;
    pad  = mv && dy && ny + S == py1 && px1 <= nx + S && nx <= px2 + S;
    dx_n = wl ? 1'b1 : wr ? 1'b0 : dx ^ tx;
    dy_n = wt ? 1'b1 : pad ? 1'b0 : dy ^ ty;
    lost = mv && ny >= YB;
  end
endmodule

// File: rtl/ball_ctrl.sv
// ball_ctrl: Breakout ball position, direction, block-hit handshake, serve and lives
module ball_ctrl import breakout_pkg::*; #(
  parameter int S_SIZE   = S_SIZE_DEF,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int D_HEIGHT = D_HEIGHT_DEF,
  parameter int LIVES    = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic        start,
  input  logic [11:0] i_px1,
  input  logic [11:0] i_px2,
  input  logic [11:0] i_py1,
  input  logic [1:0]  hit_block,
  output logic [11:0] s_x,
  output logic [11:0] s_y,
  output logic        col_detected,
  output logic [1:0]  o_lives,
  output logic        o_over
);
  localparam logic [11:0] S  = 12'(S_SIZE);
  localparam logic [11:0] X0 = 12'(D_WIDTH / 2);
  localparam logic [11:0] Y0 = 12'(D_HEIGHT - 40);
  localparam logic [1:0]  L0 = 2'(LIVES);
  state_t state, state_d;
  logic step, dx, dy, mdx, mdy, hit_pend, start_q, qhit, dx_n, dy_n, lost, serve_go, mv_pos;
  logic [11:0] sum, cx, cy, nx, ny;
  logic [1:0] lives_d;
  assign step     = i_ani_stb & i_animate;
  assign qhit     = state == PLAY && hit_block != HIT_NONE && !hit_pend;
  assign serve_go = state == SERVE && step && start;
  assign mv_pos   = serve_go || (state == PLAY && step);
  assign lives_d  = o_lives - 2'd1;
  // while serving the ball tracks the paddle; a serve moves it off that spot with dx=1, dy=0
  assign sum = i_px1 + i_px2;
  assign cx  = state == SERVE ? sum >> 1 : s_x;
  assign cy  = state == SERVE ? i_py1 - S - 12'd1 : s_y;
  assign mdx = state == SERVE || dx;
  assign mdy = state != SERVE && dy;
  assign nx  = mdx ? cx + 12'd1 : cx - 12'd1;
  assign ny  = mdy ? cy + 12'd1 : cy - 12'd1;
  ball_bounce #(
    .S_SIZE(S_SIZE),
    .D_WIDTH(D_WIDTH),
    .D_HEIGHT(D_HEIGHT)
  ) u_bounce (
    .mv(state == PLAY && step),
    .nx(nx),
    .ny(ny),
    .px1(i_px1),
    .px2(i_px2),
    .py1(i_py1),
    .dx(dx),
    .dy(dy),
    .hit(qhit ? hit_block : HIT_NONE),
    .dx_n(dx_n),
    .dy_n(dy_n),
    .lost(lost)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= SERVE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      SERVE:   state_d = serve_go ? PLAY : SERVE;
      PLAY:    state_d = lost ? LOST : PLAY;
      LOST:    state_d = !step ? LOST : lives_d == 2'd0 ? OVER : SERVE;
      OVER:    state_d = start && !start_q ? SERVE : OVER;
      default: state_d = SERVE;
    endcase
  end
  always_comb begin
    o_over = state == OVER;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      s_x          <= X0;
      s_y          <= Y0;
      dx           <= 1'b1;
      dy           <= 1'b0;
      hit_pend     <= 1'b0;
      col_detected <= 1'b0;
      start_q      <= 1'b0;
      o_lives      <= L0;
    end else begin
      s_x          <= mv_pos ? nx : cx;
      s_y          <= mv_pos ? ny : cy;
      dx           <= serve_go | dx_n;
      dy           <= !serve_go & dy_n;
      hit_pend     <= hit_block != HIT_NONE && (hit_pend || qhit);
      col_detected <= qhit;
      start_q      <= start;
      o_lives      <= state == LOST && step ? lives_d : state == OVER && start && !start_q ? L0 : o_lives;
    end
endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: randomized scoreboard bench against an integer game-rule model
module tb_ball_ctrl;
  localparam int S = 5, W = 640, H = 480, LV = 3;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_ani_stb = 1'b0, i_animate = 1'b0, start = 1'b0;
  logic [11:0] i_px1 = 12'd290, i_px2 = 12'd350, i_py1 = 12'd460;
  logic [1:0] hit_block = 2'b00;
  logic [11:0] s_x, s_y;
  logic col_detected, o_over;
  logic [1:0] o_lives;
  typedef struct { int x; int y; int col; int lives; int over; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  int m_st, mx, my, mdx, mdy, mpend, mlives, mprev;
  always #5 i_clk = ~i_clk;
  ball_ctrl #(.S_SIZE(S), .D_WIDTH(W), .D_HEIGHT(H), .LIVES(LV)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_ani_stb(i_ani_stb),
    .i_animate(i_animate),
    .start(start),
    .i_px1(i_px1),
    .i_px2(i_px2),
    .i_py1(i_py1),
    .hit_block(hit_block),
    .s_x(s_x),
    .s_y(s_y),
    .col_detected(col_detected),
    .o_lives(o_lives),
    .o_over(o_over)
  );
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, e);
    end
  endtask
  task automatic model_reset();
    m_st = 0; mx = W / 2; my = H - 40; mdx = 1; mdy = 0; mpend = 0; mlives = LV; mprev = 0;
  endtask
  // game states in the model: 0 serve, 1 play, 2 lost, 3 over
  task automatic model(input int stp, input int st, input int px1, input int px2, input int py1, input int hb);
    int nst, nx, ny, ndx, ndy, nl, q;
    nst = m_st; nx = mx; ny = my; ndx = mdx; ndy = mdy; nl = mlives;
    q = (m_st == 1 && hb != 0 && !mpend) ? 1 : 0;
    case (m_st)
      0: begin
        nx = (px1 + px2) / 2;
        ny = py1 - S - 1;
        if (stp && st) begin nx++; ny--; ndx = 1; ndy = 0; nst = 1; end
      end
      1: begin
        if (q && (hb & 2)) ndx = 1 - ndx;
        if (q && (hb & 1)) ndy = 1 - ndy;
        if (stp) begin
          nx = (mx + (mdx ? 1 : -1)) & 12'hfff;
          ny = (my + (mdy ? 1 : -1)) & 12'hfff;
          if (nx <= S) ndx = 1;
          if (nx >= W - 1 - S) ndx = 0;
          if (ny <= S) ndy = 1;
          if (mdy && ny + S == py1 && px1 - S <= nx && nx <= px2 + S) ndy = 0;
          if (ny >= H - 1 - S) nst = 2;
        end
      end
      2: if (stp) begin nl = mlives - 1; nst = nl == 0 ? 3 : 0; end
      default: if (st && !mprev) begin nl = LV; nst = 0; end
    endcase
    mpend = (hb != 0 && (mpend || q)) ? 1 : 0;
    mprev = st;
    m_st = nst; mx = nx; my = ny; mdx = ndx; mdy = ndy; mlives = nl;
    sb.push_back('{nx, ny, q, nl, nst == 3 ? 1 : 0});
  endtask
  task automatic drive(input int stb, input int an, input int st, input int px1, input int px2, input int py1, input int hb);
    i_ani_stb = stb[0]; i_animate = an[0]; start = st[0];
    i_px1 = 12'(px1); i_px2 = 12'(px2); i_py1 = 12'(py1); hit_block = 2'(hb);
    model(stb & an, st, px1, px2, py1, hb);
    @(posedge i_clk); #2;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_sx"}, s_x, W / 2);
    chk({tag, "_sy"}, s_y, H - 40);
    chk({tag, "_col"}, col_detected, 0);
    chk({tag, "_lives"}, o_lives, LV);
    chk({tag, "_over"}, o_over, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_sx", s_x, e.x);
        chk("sb_sy", s_y, e.y);
        chk("sb_col", col_detected, e.col);
        chk("sb_lives", o_lives, e.lives);
        chk("sb_over", o_over, e.over);
      end
    end
  end
  initial begin
    int stb, an, st, px1, px2, py1, hb, hold, pulses;
    model_reset();
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    chk_reset("reset");
    drive(1, 1, 1, 290, 350, 460, 0);
    chk("serve_sx", s_x, 321);
    chk("serve_sy", s_y, 453);
    pulses = 0;
    repeat (5) begin drive(0, 1, 1, 290, 350, 460, 1); pulses += col_detected; end
    chk("held_vert_pulses", pulses, 1);
    drive(0, 1, 1, 290, 350, 460, 0);
    pulses = 0;
    repeat (2) begin drive(0, 1, 1, 290, 350, 460, 2); pulses += col_detected; end
    chk("horz_pulses", pulses, 1);
    st = 1; px1 = 290; px2 = 350; py1 = 460; hb = 0; hold = 0;
    for (int c = 0; c < 40000; c++) begin
      if (c == 20000) begin
        for (int k = 0; k < 5000 && m_st != 1; k++) drive(1, 1, 1, px1, px2, py1, 0);
        #1 i_rst_n = 1'b0;
        #1 chk_reset("async_reset");
        @(posedge i_clk); #2;
        chk_reset("reset_hold");
        i_rst_n = 1'b1;
        model_reset();
        hb = 0; hold = 0;
      end
      stb = $urandom_range(0, 2) != 0 ? 1 : 0;
      an = $urandom_range(0, 15) != 0 ? 1 : 0;
      if ($urandom_range(0, 39) == 0) st = 1 - st;
      if ($urandom_range(0, 63) == 0) begin
        px1 = $urandom_range(0, 560);
        px2 = px1 + $urandom_range(40, 79);
        py1 = $urandom_range(0, 1) != 0 ? 460 : $urandom_range(440, 470);
      end
      if (hold > 0) hold--;
      else if (hb != 0) hb = 0;
      else if ($urandom_range(0, 39) == 0) begin hb = $urandom_range(1, 3); hold = $urandom_range(0, 5); end
      drive(stb, an, st, px1, px2, py1, hb);
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
